// File: rtl/h_checkpass.sv
// h_checkpass: keypad password verifier with timed unlock and failure lockout.
module h_checkpass #(
  parameter int unsigned OPEN_CYCLES = 150_000_000,
  parameter int unsigned LOCK_CYCLES = 1_500_000_000,
  parameter int unsigned MAX_FAIL    = 3
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        enb_check,
  input  logic        set_busy,
  input  logic        digit_valid,
  input  logic [3:0]  value_4bit,
  input  logic [15:0] password,
  output logic        unlock,
  output logic        fail,
  output logic        locked_out,
  output logic [2:0]  entry_count,
  output logic [1:0]  fail_count,
  output logic [15:0] disp_digits
);
  typedef enum logic [2:0] {IDLE, ENTRY, COMPARE, OPEN, FAIL, LOCKOUT} state_t;
  localparam logic [30:0] OPEN_LOAD = 31'(OPEN_CYCLES - 1);
  localparam logic [30:0] LOCK_LOAD = 31'(LOCK_CYCLES - 1);
  state_t      state, state_n;
  logic [15:0] entry, entry_n, disp_n;
  logic [30:0] timer, timer_n;
  logic [2:0]  cnt_n;
  logic [1:0]  fcnt_n;
  logic        unlock_n, fail_n, lo_n, abort, take;
  assign abort = set_busy | ~enb_check;
  assign take  = digit_valid & (value_4bit <= 4'd9);
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state       <= IDLE;
      entry       <= '0;
      disp_digits <= 16'hFFFF;
      timer       <= '0;
      entry_count <= '0;
      fail_count  <= '0;
      unlock      <= 1'b0;
      fail        <= 1'b0;
      locked_out  <= 1'b0;
    end else begin
      state       <= state_n;
      entry       <= entry_n;
      disp_digits <= disp_n;
      timer       <= timer_n;
      entry_count <= cnt_n;
      fail_count  <= fcnt_n;
      unlock      <= unlock_n;
      fail        <= fail_n;
      locked_out  <= lo_n;
    end
  end
  // Entry shifts in from the top so d1 lands at [3:0] after four digits.
  always_comb begin
    state_n  = state;
    entry_n  = entry;
    disp_n   = disp_digits;
    timer_n  = timer;
    cnt_n    = entry_count;
    fcnt_n   = fail_count;
    unlock_n = unlock;
    fail_n   = 1'b0;
    lo_n     = locked_out;
    case (state)
      IDLE, ENTRY: begin
        if (abort) begin
          state_n = IDLE;
          entry_n = '0;
          disp_n  = 16'hFFFF;
          cnt_n   = '0;
        end else if (take) begin
          entry_n = {value_4bit, entry[15:4]};
          disp_n  = {disp_digits[11:0], value_4bit};
          cnt_n   = entry_count + 3'd1;
          state_n = (entry_count == 3'd3) ? COMPARE : ENTRY;
        end
      end
      COMPARE: begin
        if (entry == password) begin
          state_n  = OPEN;
          fcnt_n   = '0;
          unlock_n = 1'b1;
          timer_n  = OPEN_LOAD;
        end else begin
          state_n = FAIL;
          fcnt_n  = fail_count + 2'd1;
          fail_n  = 1'b1;
        end
      end
      OPEN: begin
        if (timer == '0) begin
          state_n  = IDLE;
          unlock_n = 1'b0;
          entry_n  = '0;
          disp_n   = 16'hFFFF;
          cnt_n    = '0;
        end else begin
          timer_n = timer - 31'd1;
        end
      end
      FAIL: begin
        entry_n = '0;
        disp_n  = 16'hFFFF;
        cnt_n   = '0;
        state_n = (fail_count == 2'(MAX_FAIL)) ? LOCKOUT : IDLE;
        lo_n    = (fail_count == 2'(MAX_FAIL));
        timer_n = (fail_count == 2'(MAX_FAIL)) ? LOCK_LOAD : timer;
      end
      LOCKOUT: begin
        if (timer == '0) begin
          state_n = IDLE;
          lo_n    = 1'b0;
          fcnt_n  = '0;
        end else begin
          timer_n = timer - 31'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
